// File: rtl/vn_core_to_net_packetizer.sv
// vn_core_to_net_packetizer: per-VN TX stage that buffers whole core packets and streams them as flits.
// Define VN_CTN_SHORT_PACKET_EN to add packet_has_data, which sends data-less packets as a single HT flit.
`ifndef PAYLOAD_W
`define PAYLOAD_W 64
`endif

package vn_ctn_pkg;
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } tile_address_t;

    typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HT = 2'd3} flit_type_t;
    typedef enum logic [1:0] {VC0 = 2'd0, VC1 = 2'd1, VC2 = 2'd2, VC3 = 2'd3} vc_id_t;

    typedef struct packed {
        flit_type_t    flit_type;
        vc_id_t        vc_id;
        tile_address_t destination;
    } flit_header_t;

    typedef struct packed {
        flit_header_t            header;
        logic [`PAYLOAD_W-1:0]   payload;
    } flit_t;
endpackage

module vn_core_to_net_packetizer
    import vn_ctn_pkg::*;
#(
    parameter vc_id_t      VCID             = VC0,
    parameter int unsigned PACKET_BODY_SIZE = 554,
    parameter int unsigned PACKET_FIFO_SIZE = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        packet_valid,
    input  logic [PACKET_BODY_SIZE-1:0] packet_body,
    input  tile_address_t               packet_destination,
`ifdef VN_CTN_SHORT_PACKET_EN
    input  logic                        packet_has_data,
`endif
    output logic                        vn_ctn_full,
    output logic                        ni_flit_valid,
    output flit_t                       ni_flit_out,
    input  logic                        router_credit
);

    localparam int unsigned PW        = `PAYLOAD_W;
    localparam int unsigned FLIT_NUMB = (PACKET_BODY_SIZE + PW - 1) / PW;
    localparam int unsigned CNT_W     = $clog2(FLIT_NUMB + 1);
    localparam int unsigned PTR_W     = $clog2(PACKET_FIFO_SIZE);
    localparam int unsigned OCC_W     = $clog2(PACKET_FIFO_SIZE + 1);

    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FLIT_NUMB - 1);
    localparam logic [PTR_W-1:0] FIFO_LAST  = PTR_W'(PACKET_FIFO_SIZE - 1);
    localparam logic [OCC_W-1:0] FIFO_DEPTH = OCC_W'(PACKET_FIFO_SIZE);

    typedef struct packed {
        logic                        has_data;
        tile_address_t               dest;
        logic [PACKET_BODY_SIZE-1:0] body;
    } entry_t;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             flit_valid_q, flit_valid_d;
    flit_t            flit_out_q, flit_out_d;
    entry_t           pkt_q, pkt_d;
    entry_t           mem_q [PACKET_FIFO_SIZE];

    logic             in_has_data;
    logic             fifo_full, fifo_empty;
    logic             enq, deq;
    logic             is_last;
    logic [CNT_W-1:0] last_idx_cur;
    logic [FLIT_NUMB*PW-1:0] padded;
    flit_t            cur_flit;

`ifdef VN_CTN_SHORT_PACKET_EN
    assign in_has_data = packet_has_data;
`else
    assign in_has_data = 1'b1;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == FIFO_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_full   = (occ_q == FIFO_DEPTH);
    assign fifo_empty  = (occ_q == '0);
    // A full FIFO refuses the write even when the serializer frees a slot on the same edge.
    assign enq         = packet_valid & ~fifo_full;
    assign vn_ctn_full = fifo_full;

    always_comb begin
        wr_ptr_d = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q;
        case ({enq, deq})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        pkt_d = deq ? mem_q[rd_ptr_q] : pkt_q;
    end

    always_comb begin
        last_idx_cur = pkt_q.has_data ? LAST_IDX : '0;
        is_last      = (cnt_q == last_idx_cur);
        padded       = '0;
        padded[PACKET_BODY_SIZE-1:0] = pkt_q.body;

        cur_flit                    = '0;
        cur_flit.payload            = PW'(padded >> (32'(cnt_q) * PW));
        cur_flit.header.vc_id       = VCID;
        cur_flit.header.destination = pkt_q.dest;
        if (last_idx_cur == '0) begin
            cur_flit.header.flit_type = HT;
        end else if (cnt_q == '0) begin
            cur_flit.header.flit_type = HEAD;
        end else if (is_last) begin
            cur_flit.header.flit_type = TAIL;
        end else begin
            cur_flit.header.flit_type = BODY;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flit_valid_d = 1'b0;
        flit_out_d   = flit_out_q;
        deq          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    deq     = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (enable && !router_credit) begin
                    flit_valid_d = 1'b1;
                    flit_out_d   = cur_flit;
                    if (is_last) begin
                        // Chain straight into the next queued packet so TAIL is followed by HEAD.
                        cnt_d = '0;
                        if (!fifo_empty) begin
                            deq = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            flit_valid_q <= 1'b0;
            flit_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            flit_valid_q <= flit_valid_d;
            flit_out_q   <= flit_out_d;
        end
    end

    // Storage needs no reset: occupancy and state gate every read.
    always_ff @(posedge clk) begin
        pkt_q <= pkt_d;
        if (enq) begin
            mem_q[wr_ptr_q] <= '{has_data: in_has_data, dest: packet_destination, body: packet_body};
        end
    end

    assign ni_flit_valid = flit_valid_q;
    assign ni_flit_out   = flit_out_q;

endmodule
